// File: rtl/encoder_pkg.sv
// Shared types and helpers for the round-robin request encoder family.
package encoder_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned IDX_W = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // True when more than one request bit is set (a collision).
  function automatic logic multi_bit(input logic [N_REQ-1:0] v);
    return ($countones(v) > 1);
  endfunction

endpackage

// File: rtl/encoder_42_rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr.
module encoder_42_rr_pick
  import encoder_pkg::*;
(
  input  logic [N_REQ-1:0] a,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] g,
  output logic             any
);

  logic [2*N_REQ-1:0] dbl;
  logic [2*N_REQ-1:0] shifted;
  logic [N_REQ-1:0]   rot;
  logic [IDX_W-1:0]   off;

  assign dbl     = {a, a};
  assign shifted = dbl >> ptr;
  assign rot     = shifted[N_REQ-1:0];
  assign any     = |a;

  // Lowest set bit of the rotated vector; descending scan so the lowest wins.
  always_comb begin
    off = '0;
    for (int unsigned i = N_REQ; i > 0; i--) begin
      if (rot[i-1]) off = IDX_W'(i - 1);
    end
  end

  // Undo the rotation; 2-bit add wraps mod 4.
  assign g = off + ptr;

endmodule

// File: rtl/encoder_42_rr.sv
// Registered 4-to-2 encoder with round-robin collision resolution,
// valid/ready hold and a saturating collision counter.
module encoder_42_rr
  import encoder_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] a,
  input  logic             ready,
  input  logic             clr_cnt,
  output logic [IDX_W-1:0] y,
  output logic             valid,
  output logic             multi,
  output logic [CNT_W-1:0] coll_cnt,
  output logic [IDX_W-1:0] ptr
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] y_d, ptr_d;
  logic             multi_d;
  logic [CNT_W-1:0] cnt_d;
  logic [IDX_W-1:0] g;
  logic             any;
  logic             cw;
  logic             coll;

  encoder_42_rr_pick u_pick (
    .a   (a),
    .ptr (ptr),
    .g   (g),
    .any (any)
  );

  assign cw    = (state_q == ST_IDLE) || ready;
  assign coll  = multi_bit(a);
  assign valid = (state_q == ST_HOLD);

  // Next-state and next-output logic; everything holds outside the capture window.
  always_comb begin
    state_d = state_q;
    y_d     = y;
    multi_d = multi;
    ptr_d   = ptr;
    if (cw) begin
      if (any) begin
        state_d = ST_HOLD;
        y_d     = g;
        multi_d = coll;
        ptr_d   = g + IDX_W'(1);
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  // Collision counter: clear beats increment, increment saturates at all-ones.
  always_comb begin
    cnt_d = coll_cnt;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (cw && any && coll && (coll_cnt != '1)) begin
      cnt_d = coll_cnt + CNT_W'(1);
    end
  end

  // State, output, pointer and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      y        <= '0;
      multi    <= 1'b0;
      ptr      <= '0;
      coll_cnt <= '0;
    end else begin
      state_q  <= state_d;
      y        <= y_d;
      multi    <= multi_d;
      ptr      <= ptr_d;
      coll_cnt <= cnt_d;
    end
  end

endmodule

// File: tb/tb_encoder_42_rr.sv
// Directed self-checking bench for encoder_42_rr (CNT_W=8 and CNT_W=2 instances).
module tb_encoder_42_rr;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] a;
  logic       ready;
  logic       clr_cnt;

  logic [1:0] y, ptr;
  logic       valid, multi;
  logic [7:0] coll_cnt;

  logic [1:0] y_s, ptr_s;
  logic       valid_s, multi_s;
  logic [1:0] coll_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  encoder_42_rr #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .a(a), .ready(ready), .clr_cnt(clr_cnt),
    .y(y), .valid(valid), .multi(multi), .coll_cnt(coll_cnt), .ptr(ptr)
  );

  encoder_42_rr #(.CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .a(a), .ready(ready), .clr_cnt(clr_cnt),
    .y(y_s), .valid(valid_s), .multi(multi_s), .coll_cnt(coll_s), .ptr(ptr_s)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    a = 4'b0001; ready = 1'b1; clr_cnt = 1'b0;
    step();
    total++;
    if (valid !== 1'b1 || y !== 2'd0 || ptr !== 2'd1) begin
      bad++;
      $display("FAIL pre_reset: valid=%b y=%0d ptr=%0d required valid=1 y=0 ptr=1", valid, y, ptr);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (y !== 2'd0 || valid !== 1'b0 || multi !== 1'b0 || ptr !== 2'd0 || coll_cnt !== 8'd0) begin
      bad++;
      $display("FAIL async_reset: y=%0d valid=%b multi=%b ptr=%0d cnt=%0d required all 0",
               y, valid, multi, ptr, coll_cnt);
    end
    a = 4'b0000;
    step();
    rst = 1'b0;
  endtask

  task automatic test_encode_sweep;
    logic [3:0] vec [4];
    vec[0] = 4'b0001; vec[1] = 4'b0010; vec[2] = 4'b0100; vec[3] = 4'b1000;
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = vec[i];
      step();
      total++;
      if (y !== 2'(i) || valid !== 1'b1 || multi !== 1'b0 || ptr !== 2'(i + 1)) begin
        bad++;
        $display("FAIL sweep[%0d]: y=%0d valid=%b multi=%b ptr=%0d required y=%0d valid=1 multi=0 ptr=%0d",
                 i, y, valid, multi, ptr, i, (i + 1) % 4);
      end
    end
  endtask

  task automatic test_round_robin;
    logic [1:0] exp_y [5];
    exp_y[0] = 2'd0; exp_y[1] = 2'd1; exp_y[2] = 2'd2; exp_y[3] = 2'd3; exp_y[4] = 2'd0;
    ready = 1'b1;
    a = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (y !== exp_y[i] || multi !== 1'b1 || valid !== 1'b1 || coll_cnt !== 8'(i + 1)) begin
        bad++;
        $display("FAIL rr[%0d]: y=%0d multi=%b valid=%b cnt=%0d required y=%0d multi=1 valid=1 cnt=%0d",
                 i, y, multi, valid, coll_cnt, exp_y[i], i + 1);
      end
    end
    total++;
    if (ptr !== 2'd1) begin
      bad++;
      $display("FAIL rr_ptr: ptr=%0d required 1", ptr);
    end
  endtask

  task automatic test_backpressure;
    ready = 1'b1;
    a = 4'b0010;
    step();
    total++;
    if (y !== 2'd1 || valid !== 1'b1 || ptr !== 2'd2) begin
      bad++;
      $display("FAIL bp_capture: y=%0d valid=%b ptr=%0d required y=1 valid=1 ptr=2", y, valid, ptr);
    end
    ready = 1'b0;
    a = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (y !== 2'd1 || valid !== 1'b1 || ptr !== 2'd2 || multi !== 1'b0 || coll_cnt !== 8'd5) begin
        bad++;
        $display("FAIL bp_hold[%0d]: y=%0d valid=%b ptr=%0d multi=%b cnt=%0d required y=1 valid=1 ptr=2 multi=0 cnt=5",
                 i, y, valid, ptr, multi, coll_cnt);
      end
    end
    ready = 1'b1;
    step();
    total++;
    if (y !== 2'd3 || valid !== 1'b1 || ptr !== 2'd0) begin
      bad++;
      $display("FAIL bp_release: y=%0d valid=%b ptr=%0d required y=3 valid=1 ptr=0", y, valid, ptr);
    end
  endtask

  task automatic test_idle;
    ready = 1'b1;
    a = 4'b0000;
    step();
    total++;
    if (valid !== 1'b0 || y !== 2'd3 || ptr !== 2'd0 || multi !== 1'b0) begin
      bad++;
      $display("FAIL idle: valid=%b y=%0d ptr=%0d multi=%b required valid=0 y=3 ptr=0 multi=0", valid, y, ptr, multi);
    end
    // ready is ignored while idle: capture still happens
    ready = 1'b0;
    a = 4'b0100;
    step();
    total++;
    if (valid !== 1'b1 || y !== 2'd2 || ptr !== 2'd3) begin
      bad++;
      $display("FAIL idle_capture: valid=%b y=%0d ptr=%0d required valid=1 y=2 ptr=3", valid, y, ptr);
    end
  endtask

  task automatic test_saturation;
    logic [1:0] exp_s [6];
    exp_s[0] = 2'd1; exp_s[1] = 2'd2; exp_s[2] = 2'd3;
    exp_s[3] = 2'd3; exp_s[4] = 2'd3; exp_s[5] = 2'd3;
    ready = 1'b1;
    a = 4'b0000;
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    total++;
    if (coll_cnt !== 8'd0 || coll_s !== 2'd0 || valid !== 1'b0) begin
      bad++;
      $display("FAIL sat_clear: cnt=%0d cnt_s=%0d valid=%b required 0 0 0", coll_cnt, coll_s, valid);
    end
    a = 4'b0011;
    for (int i = 0; i < 6; i++) begin
      step();
      total++;
      if (coll_s !== exp_s[i] || coll_cnt !== 8'(i + 1) || y !== 2'(i % 2) || multi_s !== 1'b1) begin
        bad++;
        $display("FAIL sat[%0d]: cnt_s=%0d cnt=%0d y=%0d multi_s=%b required cnt_s=%0d cnt=%0d y=%0d multi_s=1",
                 i, coll_s, coll_cnt, y, multi_s, exp_s[i], i + 1, i % 2);
      end
    end
  endtask

  task automatic test_clear_priority;
    ready = 1'b1;
    a = 4'b0011;
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    total++;
    if (coll_cnt !== 8'd0 || coll_s !== 2'd0 || multi !== 1'b1 || y !== 2'd0) begin
      bad++;
      $display("FAIL clr_wins: cnt=%0d cnt_s=%0d multi=%b y=%0d required cnt=0 cnt_s=0 multi=1 y=0",
               coll_cnt, coll_s, multi, y);
    end
    step();
    total++;
    if (coll_cnt !== 8'd1 || coll_s !== 2'd1 || y !== 2'd1) begin
      bad++;
      $display("FAIL clr_next: cnt=%0d cnt_s=%0d y=%0d required cnt=1 cnt_s=1 y=1", coll_cnt, coll_s, y);
    end
  endtask

  initial begin
    rst = 1'b1; a = 4'b0000; ready = 1'b0; clr_cnt = 1'b0;
    #12 rst = 1'b0;
    test_reset();
    test_encode_sweep();
    test_round_robin();
    test_backpressure();
    test_idle();
    test_saturation();
    test_clear_priority();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/encoder_42_rr.md
Name: encoder_42_rr

Overview:
- Registered 4-to-2 encoder. Converts a 4-bit request/one-hot vector into a 2-bit binary index; the inverse of the 2-to-4 decoder.
- Multiple active bits are resolved by round-robin priority. The result is held under valid/ready backpressure.
- Counts multi-bit (collision) captures for diagnostics.
- Sits between request sources and any consumer of a 2-bit select code.

Parameters:
- CNT_W, 8, width of the saturating collision counter (2..16).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- a  input  4  request vector; bit i set means request i active
- ready  input  1  consumer accepts y this cycle when valid=1
- clr_cnt  input  1  synchronous clear of coll_cnt
- y  output  2  encoded index of the granted request
- valid  output  1  y holds a captured result
- multi  output  1  the capture producing y had more than one bit of a set
- coll_cnt  output  CNT_W  saturating count of captures with multi=1
- ptr  output  2  current round-robin priority pointer (debug)

Behaviour:
- Reset (async assert, sync deassert handled by system): y=0, valid=0, multi=0, ptr=0, coll_cnt=0, state=IDLE. Reset mid-HOLD drops the held result immediately.
- States: IDLE (valid=0), HOLD (valid=1).
- Capture window (cw): state==IDLE, or state==HOLD && ready==1.
- On a clk edge with cw=1 and a!=0:
  - Grant index g = first set bit of a searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - Next state: y<=g, valid<=1, multi<=(popcount(a)>1), ptr<=g+1 mod 4 (3 wraps to 0), state<=HOLD.
- On a clk edge with cw=1 and a==0: valid<=0, state<=IDLE. y, multi and ptr hold their values.
- state==HOLD && ready==0: y, multi, valid and ptr all hold; a is ignored, not queued.
- Latency: a sampled at edge k appears on y/valid after edge k; 1 cycle. Back-to-back with ready=1 sustains 1 result/cycle.
- ready while valid=0 is don't-care.
- coll_cnt:
  - Increments by 1 on each capture with popcount(a)>1.
  - Saturates at 2^CNT_W-1.
  - clr_cnt=1 forces 0 on the next edge. Clear wins over a simultaneous increment.
- One-hot input yields the plain encoding regardless of ptr, e.g. a=4'b0100 -> y=2. ptr still advances to g+1.
- All outputs come directly from flops; there is no combinational path from a or ready to any output.

Decomposition:
- Shared package encoder_pkg:
  - localparams N_REQ=4, IDX_W=2
  - state encoding ST_IDLE=1'b0, ST_HOLD=1'b1
  - function for popcount>1
- One natural sub-module: encoder_42_rr_pick.
  - Combinational; inputs a and ptr; outputs g and any.
  - Rotate a by ptr, take the lowest set bit, add ptr back mod 4.
  - Reusable by other arbiters.
- Top: state/output/ptr/counter registers only.

Test Plan:
- Reset: hold rst=1 mid-stream with valid=1 -> y=0, valid=0, multi=0, ptr=0, coll_cnt=0 immediately, without waiting for a clk edge.
- Encode sweep: ready=1, apply a=0001,0010,0100,1000 on consecutive cycles -> y=0,1,2,3 one cycle later, valid=1, multi=0, ptr=1,2,3,0.
- Round-robin: ready=1, ptr=0, hold a=1111 for 5 cycles -> y=0,1,2,3,0; multi=1 each; coll_cnt=5.
- Backpressure: a=0010 captured (y=1,valid=1), then ready=0 for 3 cycles while a=1000 -> y stays 1, ptr stays 2; ready=1 -> next y=3.
- Idle and saturation:
  - a=0000 with ready=1 -> valid=0 next cycle, y unchanged.
  - CNT_W=2 with a=0011 for 6 captures -> coll_cnt=3, holds at 3.
- Clear priority: clr_cnt=1 on the same edge as a collision capture -> coll_cnt=0; next collision -> 1.
